// File: rtl/qdec_pkg.sv
// Shared types and helpers for the sequential quantized dense decoder.
// Saturation is selected by the QDEC_SATURATE_EN macro (see qdec_quant.sv).
package qdec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        QUANT = 2'd2,
        OUT   = 2'd3
    } qdec_state_e;

    // Accumulator width: product width plus growth for XD terms and the bias.
    function automatic int calc_ab(input int xb, input int kb, input int xd);
        return xb + kb + $clog2(xd + 1);
    endfunction

endpackage

// File: rtl/qdec_quant.sv
// One output lane: arithmetic shift, ReLU, then wrap or saturate to YQB bits.
// Define QDEC_SATURATE_EN to clamp at 2^YQB-1; otherwise the low YQB bits wrap.
module qdec_quant #(
    parameter int AB    = 26,
    parameter int SHIFT = 13,
    parameter int YQB   = 11
) (
    input  logic signed [AB-1:0] acc,
    output logic        [YQB:0]  q
);

`ifdef QDEC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic signed [AB-1:0] t;
    logic                 over;

    assign t    = acc >>> SHIFT;
    // Any set bit between the sign and the kept field means the value exceeds 2^YQB-1.
    assign over = |t[AB-2:YQB];

    always_comb begin
        q = {1'b0, t[YQB-1:0]};
        if (t[AB-1]) begin
            q = '0;
        end else if (SAT_EN && over) begin
            q = {1'b0, {YQB{1'b1}}};
        end
    end

endmodule

// File: rtl/register.sv
// Serially loaded shift register; new bits enter at the MSB and move toward bit 0.
module register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic         d,
    output logic [W-1:0] q
);

    // Intentionally not reset: weight contents survive a datapath reset.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= {d, q[W-1:1]};
        end
    end

endmodule

// File: rtl/qdense_seq_decoder.sv
// Sequential quantized dense decoder: XD latent words in, YD quantized outputs out,
// one latent element per MAC cycle across YD lanes. Optional macro: QDEC_SATURATE_EN.
module qdense_seq_decoder
    import qdec_pkg::*;
#(
    parameter int XD    = 16,
    parameter int XB    = 14,
    parameter int YD    = 64,
    parameter int KB    = 7,
    parameter int SHIFT = 13,
    parameter int YQB   = 11
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  copy,
    input  logic                  k,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [XD*XB-1:0]      x,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [YD*(YQB+1)-1:0] y
);

    localparam int YB        = YQB + 1;
    localparam int AB        = calc_ab(XB, KB, XD);
    localparam int WEIGHTS_B = (XD * YD + YD) * KB;
    localparam int IW        = (XD > 1) ? $clog2(XD) : 1;
    localparam int PB        = XB + KB;

    qdec_state_e            state_reg, state_next;
    logic [IW-1:0]          idx_reg;
    logic [XD*XB-1:0]       x_reg;
    logic [WEIGHTS_B-1:0]   weights_q;
    logic                   accept;
    logic                   shift_en;
    logic signed [XB-1:0]   x_cur;

    assign accept   = (state_reg == IDLE) && s_valid;
    assign shift_en = copy && (state_reg == IDLE);
    assign x_cur    = x_reg[idx_reg*XB +: XB];

    register #(
        .W (WEIGHTS_B)
    ) u_weights (
        .clk (clk),
        .en  (shift_en),
        .d   (k),
        .q   (weights_q)
    );

    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (idx_reg == IW'(XD - 1)) begin
                    state_next = QUANT;
                end
            end
            QUANT: begin
                state_next = OUT;
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            x_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                x_reg   <= x;
                idx_reg <= '0;
            end else if (state_reg == MAC) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < YD; gi++) begin : g_lane
        logic signed [KB-1:0] w_cur;
        logic signed [KB-1:0] b_cur;
        logic signed [PB-1:0] prod;
        logic signed [AB-1:0] acc_reg;
        logic [YB-1:0]        q_lane;
        logic [YB-1:0]        y_reg;

        assign w_cur = weights_q[(idx_reg*YD + gi)*KB +: KB];
        assign b_cur = weights_q[XD*YD*KB + gi*KB +: KB];
        assign prod  = x_cur * w_cur;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                acc_reg <= '0;
            end else if (accept) begin
                acc_reg <= {{(AB-KB){b_cur[KB-1]}}, b_cur};
            end else if (state_reg == MAC) begin
                acc_reg <= acc_reg + {{(AB-PB){prod[PB-1]}}, prod};
            end
        end

        qdec_quant #(
            .AB    (AB),
            .SHIFT (SHIFT),
            .YQB   (YQB)
        ) u_quant (
            .acc (acc_reg),
            .q   (q_lane)
        );

        // Output word is captured once and held through any backpressure.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                y_reg <= '0;
            end else if (state_reg == QUANT) begin
                y_reg <= q_lane;
            end
        end

        assign y[gi*YB +: YB] = y_reg;
    end

endmodule

// File: tb/tb_qdense_seq_decoder.sv
// Scoreboard bench for qdense_seq_decoder run with SHIFT=0; honours QDEC_SATURATE_EN.
module tb_qdense_seq_decoder;

    localparam int XD        = 16;
    localparam int XB        = 14;
    localparam int YD        = 64;
    localparam int KB        = 7;
    localparam int SHIFT     = 0;
    localparam int YQB       = 11;
    localparam int YB        = YQB + 1;
    localparam int WEIGHTS_B = (XD * YD + YD) * KB;
    localparam int CW        = YD * YB;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 copy;
    logic                 k;
    logic                 s_valid;
    logic                 s_ready;
    logic [XD*XB-1:0]     x;
    logic                 m_valid;
    logic                 m_ready;
    logic [CW-1:0]        y;

    logic [WEIGHTS_B-1:0] wv;
    logic [CW-1:0]        exp_q [$];
    int                   n_cmp = 0;
    int                   n_bad = 0;

    always #5 clk = ~clk;

    qdense_seq_decoder #(
        .XD    (XD),
        .XB    (XB),
        .YD    (YD),
        .KB    (KB),
        .SHIFT (SHIFT),
        .YQB   (YQB)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .copy    (copy),
        .k       (k),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .x       (x),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .y       (y)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference model: bias + dot product, floor shift, ReLU, wrap or saturate.
    function automatic logic [CW-1:0] model(input logic [XD*XB-1:0] xv);
        logic [CW-1:0]        r;
        logic signed [KB-1:0] wk;
        logic signed [XB-1:0] xe;
        longint               acc;
        longint               t;
        longint               yq;
        r = '0;
        for (int j = 0; j < YD; j++) begin
            wk  = wv[XD*YD*KB + j*KB +: KB];
            acc = wk;
            for (int i = 0; i < XD; i++) begin
                wk  = wv[(i*YD + j)*KB +: KB];
                xe  = xv[i*XB +: XB];
                acc = acc + longint'(xe) * longint'(wk);
            end
            t = acc >>> SHIFT;
            if (t < 0) yq = 0;
`ifdef QDEC_SATURATE_EN
            else if (t > 2047) yq = 2047;
`endif
            else yq = t & 2047;
            r[j*YB +: YB] = yq[YB-1:0];
        end
        return r;
    endfunction

    function automatic logic [XD*XB-1:0] fill_x(input logic [XB-1:0] v);
        logic [XD*XB-1:0] r;
        for (int i = 0; i < XD; i++) r[i*XB +: XB] = v;
        return r;
    endfunction

    function automatic logic [XD*XB-1:0] rand_x();
        logic [XD*XB-1:0] r;
        for (int i = 0; i < XD; i++) r[i*XB +: XB] = XB'($urandom);
        return r;
    endfunction

    task automatic set_uniform(input logic [KB-1:0] wval);
        wv = '0;
        for (int i = 0; i < XD*YD; i++) wv[i*KB +: KB] = wval;
    endtask

    task automatic set_random();
        for (int i = 0; i < WEIGHTS_B; i++) wv[i] = 1'($urandom);
    endtask

    task automatic load_weights();
        for (int i = 0; i < WEIGHTS_B; i++) begin
            copy = 1'b1;
            k    = wv[i];
            @(negedge clk);
        end
        copy = 1'b0;
        k    = 1'b0;
    endtask

    // Drive one latent vector; returns at the first falling edge after the handshake.
    task automatic send(input logic [XD*XB-1:0] xv);
        int guard = 0;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("s_ready_idle", CW'(s_ready), CW'(1));
        s_valid = 1'b1;
        x       = xv;
        @(posedge clk);
        exp_q.push_back(model(xv));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold, input int exp_lat);
        int            lat = 1;
        logic          stable = 1'b1;
        logic [CW-1:0] y0;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_mvalid"}, CW'(m_valid), CW'(1));
        if (exp_lat > 0) check({tag, "_lat"}, CW'(lat), CW'(exp_lat));
        y0 = y;
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'b1;
            x       = rand_x();
            @(negedge clk);
            if (y !== y0 || !m_valid || s_ready) stable = 1'b0;
        end
        s_valid = 1'b0;
        if (hold > 0) check({tag, "_bp_stable"}, CW'(stable), CW'(1));
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, CW'(0), CW'(1));
        else check({tag, "_y"}, y, exp_q.pop_front());
        $display("txn %s: latency=%0d y[0]=%0d y[%0d]=%0d", tag, lat, y[YB-1:0], YD-1, y[CW-1 -: YB]);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_back_idle"}, CW'({s_ready, m_valid}), CW'(2'b10));
    endtask

    task automatic pulse_reset(input string tag);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check({tag, "_s_ready"}, CW'(s_ready), CW'(1));
        check({tag, "_m_valid"}, CW'(m_valid), CW'(0));
        check({tag, "_y"}, y, '0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    initial begin
        int                 guard;
        logic [XD*XB-1:0]   xr;
        rstn    = 1'b0;
        copy    = 1'b0;
        k       = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        x       = '0;
        wv      = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("rst_s_ready", CW'(s_ready), CW'(1));
        check("rst_m_valid", CW'(m_valid), CW'(0));
        check("rst_y", y, '0);

        // All weights +1, zero bias: 16 * 3 = 48 per lane.
        set_uniform(7'sd1);
        load_weights();
        send(fill_x(14'd3));
        check("plus1_y0_48", CW'(model(fill_x(14'd3)) & CW'(12'hfff)), CW'(48));
        collect("plus1", 0, 18);

        // Backpressure with a busy upstream: output frozen, nothing new captured.
        send(fill_x(14'd3));
        collect("bp", 10, 18);

        // All weights -1: negative accumulator clamps to zero.
        set_uniform(-7'sd1);
        load_weights();
        send(fill_x(14'd3));
        collect("relu", 0, 18);

        // Large positive accumulator: saturate or wrap.
        set_uniform(7'sd63);
        load_weights();
        send(fill_x(14'd8191));
        collect("big", 0, 18);
`ifdef QDEC_SATURATE_EN
        check("big_y0_const", CW'(model(fill_x(14'd8191)) & CW'(12'hfff)), CW'(2047));
`else
        check("big_y0_const", CW'(model(fill_x(14'd8191)) & CW'(12'hfff)), CW'(1040));
`endif

        // Random weights and biases; copy pulses during MAC must not disturb weights.
        set_random();
        load_weights();
        send(rand_x());
        for (int c = 0; c < 5; c++) begin
            copy = 1'b1;
            k    = 1'($urandom);
            @(negedge clk);
        end
        copy = 1'b0;
        collect("copy_mac", 0, 0);

        // Reset in the middle of MAC, then a clean transaction.
        send(rand_x());
        repeat (4) @(negedge clk);
        pulse_reset("rst_mac");
        send(rand_x());
        collect("after_rst", 0, 18);

        // Reset while holding a result in OUT.
        send(rand_x());
        guard = 0;
        while (!m_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("out_reached", CW'(m_valid), CW'(1));
        pulse_reset("rst_out");

        xr = rand_x();
        send(xr);
        collect("final", 0, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qdense_seq_decoder.md
# qdense_seq_decoder

Sequential quantized dense decoder: the receiving end of the encoder's latent interface. It accepts one latent vector (XD signed fixed-point words) per transaction over a valid/ready handshake. It computes YD dense outputs with YD parallel MAC lanes, consuming one latent element per cycle, then applies shift/ReLU/quantize and presents the result on a valid/ready output. Weights and biases are held in a serially loaded shift register using the same `copy`/`k` scheme as the encoder.

## Interface
- XD, 16: latent elements per transaction
- XB, 14: latent word width, signed two's complement
- YD, 64: output neurons (MAC lanes)
- KB, 7: weight/bias width, signed
- SHIFT, 13: arithmetic right shift applied to accumulator before quantize
- YQB, 11: quantized magnitude bits; output word width YB=YQB+1
- Derived: AB=XB+KB+$clog2(XD+1) accumulator width; WEIGHTS_B=(XD*YD+YD)*KB
---
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- copy  in  1  weight shift enable
- k  in  1  serial weight bit
- s_valid  in  1  latent valid
- s_ready  out  1  decoder can accept latent
- x  in  XD*XB  packed latent, element i at [i*XB +: XB]
- m_valid  out  1  output valid
- m_ready  in  1  downstream accepts output
- y  out  YD*YB  packed outputs, element j at [j*YB +: YB], unsigned (MSB always 0)

## Operation
- Weight register: on each clk with copy=1 and state IDLE: weights_q <= {k, weights_q[WEIGHTS_B-1:1]}. copy in any other state is ignored and the register holds. Not cleared by rstn.
- Layout: w[i][j] at bits ((i*YD+j)*KB +: KB); bias b[j] at (XD*YD*KB + j*KB +: KB).
- FSM states IDLE, MAC, QUANT, OUT:
  - IDLE: s_ready=1. On s_valid: x_reg<=x, acc[j]<=sext(b[j]), idx<=0, go to MAC.
  - MAC: acc[j] <= acc[j] + x_reg[idx]*w[idx][j] (signed, AB bits), idx++. After idx==XD-1, go to QUANT.
  - QUANT: y[j] <= q(acc[j]); go to OUT.
  - OUT: m_valid=1, y stable. On m_ready, go to IDLE.
- q(a): t = a >>> SHIFT (floor). If t<0, 0. Else saturate or wrap per Configuration.
- s_valid outside IDLE is ignored. x is sampled only at the handshake.
- Reset (any state, including mid-MAC): state<=IDLE, idx<=0, acc<=0, y<=0, x_reg<=0. Outputs after reset: s_ready=1, m_valid=0, y=0.

## Timing
- Input handshake at cycle 0. MAC runs cycles 1..XD. QUANT at XD+1. m_valid=1 from cycle XD+2 (18 at defaults).
- Output handshake at cycle n. s_ready=1 at n+1. No overlap between transactions; minimum period XD+3 cycles.
- m_valid and y are held unchanged until m_ready (no drop, no change).
- s_ready and m_valid are registered state decodes with no combinational path from inputs.

## Configuration
- QDEC_SATURATE_EN defined: t > 2^YQB-1 yields 2^YQB-1.
- QDEC_SATURATE_EN undefined: y = {1'b0, t[YQB-1:0]} (wrap).

## Structure
- Package qdec_pkg: state enum (IDLE, MAC, QUANT, OUT) and a function computing AB from XB/KB/XD.
- Sub-module qdec_quant: one lane of shift/ReLU/saturate, instantiated YD times via generate.
- Weight storage reuses the existing `register` module with W=WEIGHTS_B.

## Test plan
- Reset: rstn=0 for 1 cycle from any state -> s_ready=1, m_valid=0, y=0 the next cycle.
- SHIFT=0, all w=1, b=0, x all 3 -> every y[j]=48, m_valid first high 18 cycles after handshake.
- SHIFT=0, all w=-1, b=0, x all 3 -> acc=-48, every y[j]=0 (ReLU).
- SHIFT=0, all w=63, x all 8191, b=0 -> acc=8256528. With QDEC_SATURATE_EN, y=2047. Without it, y=1040.
- Backpressure: hold m_ready=0 for 10 cycles with s_valid=1 and changing x -> y and m_valid stable, s_ready=0, no new capture. The result equals the first transaction's.
- Pulse copy=1 with random k during MAC, and assert rstn=0 mid-MAC on a second run -> first result unchanged. After reset, the FSM returns to IDLE and the next transaction computes correctly.
